// File: rtl/seven_seg_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_reader_pkg
// Description : Segment patterns, FSM states and digit count for the reader.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_reader_pkg;

    localparam int c_NUM_DIGITS = 4;

    // Active-low patterns, leftmost bit is segment a
    localparam logic [0:6] c_SEG_0 = 7'b0000001;
    localparam logic [0:6] c_SEG_1 = 7'b1001111;
    localparam logic [0:6] c_SEG_2 = 7'b0010010;
    localparam logic [0:6] c_SEG_3 = 7'b0000110;
    localparam logic [0:6] c_SEG_4 = 7'b1001100;
    localparam logic [0:6] c_SEG_5 = 7'b0100100;
    localparam logic [0:6] c_SEG_6 = 7'b0100000;
    localparam logic [0:6] c_SEG_7 = 7'b0001111;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CONTANDO  = 2'd1,
        CAPTURADO = 2'd2
    } state_t;

    function automatic logic is_one_hot_low(input logic [c_NUM_DIGITS-1:0] an);
        return ($countones(~an) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_reader_if
// Description : Display-side inputs and captured-digit outputs of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_reader_if;
    import seven_seg_reader_pkg::*;

    logic [0:6]                segmentos;
    logic [c_NUM_DIGITS-1:0]   anodos;
    logic [3*c_NUM_DIGITS-1:0] valor;
    logic [c_NUM_DIGITS-1:0]   valido;
    logic [c_NUM_DIGITS-1:0]   erro;
    logic                      atualizado;

    modport master (
        output segmentos, anodos,
        input  valor, valido, erro, atualizado
    );

    modport slave (
        input  segmentos, anodos,
        output valor, valido, erro, atualizado
    );

endinterface
`default_nettype wire

// File: rtl/seven_seg_reader_seg_para_valor.sv
`default_nettype none
// ============================================================================
// Module      : seg_para_valor
// Description : Combinational decode of an active-low segment pattern to 0..7.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_para_valor
    import seven_seg_reader_pkg::*;
(
    input  wire logic [0:6] i_seg,
    output logic      [2:0] o_valor,
    output logic            o_legal
);

    always_comb begin
        o_valor = 3'd0;
        o_legal = 1'b1;
        case (i_seg)
            c_SEG_0: o_valor = 3'd0;
            c_SEG_1: o_valor = 3'd1;
            c_SEG_2: o_valor = 3'd2;
            c_SEG_3: o_valor = 3'd3;
            c_SEG_4: o_valor = 3'd4;
            c_SEG_5: o_valor = 3'd5;
            c_SEG_6: o_valor = 3'd6;
            c_SEG_7: o_valor = 3'd7;
            default: o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_reader.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_reader
// Description : Captures digits of a multiplexed 7-segment display once stable.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_reader
    import seven_seg_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  wire logic         clock,
    input  wire logic         reset_n,
    seven_seg_reader_if.slave io_bus
);

    localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

    logic [0:6]                r_seg;
    logic [c_NUM_DIGITS-1:0]   r_an;
    logic [0:6]                r_prev_seg;
    logic [c_NUM_DIGITS-1:0]   r_prev_an;
    state_t                    r_state;
    logic [7:0]                r_cnt;
    logic [3*c_NUM_DIGITS-1:0] r_valor;
    logic [c_NUM_DIGITS-1:0]   r_valido;
    logic [c_NUM_DIGITS-1:0]   r_erro;
    logic                      r_atualizado;

    state_t     w_state_next;
    logic [7:0] w_cnt_next;
    logic       w_capture;
    logic       w_same;
    logic       w_one_hot;
    logic [2:0] w_valor;
    logic       w_legal;

    // r_prev_* holds the sample one cycle older than r_*, giving the change detect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seg      <= '1;
            r_an       <= '1;
            r_prev_seg <= '1;
            r_prev_an  <= '1;
        end else begin
            r_seg      <= io_bus.segmentos;
            r_an       <= io_bus.anodos;
            r_prev_seg <= r_seg;
            r_prev_an  <= r_an;
        end
    end

    assign w_same    = (r_seg == r_prev_seg) && (r_an == r_prev_an);
    assign w_one_hot = is_one_hot_low(r_an);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= OCIOSO;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            OCIOSO: begin
                if (w_one_hot) begin
                    w_state_next = CONTANDO;
                    w_cnt_next   = 8'd1;
                end
            end
            CONTANDO: begin
                if (!w_one_hot) begin
                    w_state_next = OCIOSO;
                    w_cnt_next   = 8'd0;
                end else if (!w_same) begin
                    w_cnt_next   = 8'd1;
                end else if (r_cnt >= c_STABLE - 8'd1) begin
                    w_state_next = CAPTURADO;
                    w_cnt_next   = c_STABLE;
                    w_capture    = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            CAPTURADO: begin
                if (!w_one_hot) begin
                    w_state_next = OCIOSO;
                    w_cnt_next   = 8'd0;
                end else if (!w_same) begin
                    w_state_next = CONTANDO;
                    w_cnt_next   = 8'd1;
                end
            end
            default: begin
                w_state_next = OCIOSO;
                w_cnt_next   = 8'd0;
            end
        endcase
    end

    seg_para_valor u_seg_para_valor (
        .i_seg   (r_seg),
        .o_valor (w_valor),
        .o_legal (w_legal)
    );

    // Capture only fires with a one-hot r_an, so at most one digit is touched
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valor      <= '0;
            r_valido     <= '0;
            r_erro       <= '0;
            r_atualizado <= 1'b0;
        end else begin
            r_atualizado <= w_capture;
            for (int d = 0; d < c_NUM_DIGITS; d++) begin
                if (w_capture && !r_an[d]) begin
                    if (w_legal) begin
                        r_valor[3*d +: 3] <= w_valor;
                        r_valido[d]       <= 1'b1;
                        r_erro[d]         <= 1'b0;
                    end else begin
                        r_valido[d]       <= 1'b0;
                        r_erro[d]         <= 1'b1;
                    end
                end
            end
        end
    end

    assign io_bus.valor      = r_valor;
    assign io_bus.valido     = r_valido;
    assign io_bus.erro       = r_erro;
    assign io_bus.atualizado = r_atualizado;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_reader
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_reader;

    localparam int STABLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_reader_if bus_if ();

    seven_seg_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .io_bus  (bus_if.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    logic [0:6] pat [8];
    logic [0:6] idle_seg = 7'b1111111;
    logic [3:0] idle_an  = 4'b1111;

    // Reference model: run length of identical samples, expected digit table
    int         m_val [4];
    logic [3:0] m_valido;
    logic [3:0] m_erro;
    logic       m_atual;
    logic [10:0] last_key;
    bit          have_last;
    int          run;

    typedef struct {
        bit cap;
        int dig;
        bit legal;
        int val;
    } ev_t;
    ev_t pipe [$];

    typedef struct {
        logic [3:0]  an;
        logic [0:6]  seg;
        int          hold;
        int          exp_pulses;
        logic [11:0] exp_valor;
        logic [3:0]  exp_valido;
        logic [3:0]  exp_erro;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [0:6] s);
        for (int i = 0; i < 8; i++)
            if (s == pat[i]) return i;
        return -1;
    endfunction

    function automatic int which_digit(input logic [3:0] an);
        int zeros = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++)
            if (an[i] == 1'b0) begin
                zeros++;
                idx = i;
            end
        return (zeros == 1) ? idx : -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_val[i] = 0;
        m_valido  = 4'b0;
        m_erro    = 4'b0;
        m_atual   = 1'b0;
        have_last = 1'b0;
        run       = 0;
        pipe.delete();
    endtask

    task automatic model_sample(input logic [0:6] seg, input logic [3:0] an);
        ev_t e;
        logic [10:0] key;
        int v;
        key = {seg, an};
        if (have_last && key == last_key) run++;
        else run = 1;
        last_key  = key;
        have_last = 1'b1;
        v       = decode(seg);
        e.dig   = which_digit(an);
        e.cap   = (run == STABLE) && (e.dig >= 0);
        e.legal = (v >= 0);
        e.val   = v;
        pipe.push_back(e);
    endtask

    task automatic check_outputs();
        ev_t e;
        int exp_valor;
        m_atual = 1'b0;
        if (pipe.size() > 1) begin
            e = pipe.pop_front();
            if (e.cap) begin
                m_atual = 1'b1;
                if (e.legal) begin
                    m_val[e.dig]    = e.val;
                    m_valido[e.dig] = 1'b1;
                    m_erro[e.dig]   = 1'b0;
                end else begin
                    m_valido[e.dig] = 1'b0;
                    m_erro[e.dig]   = 1'b1;
                end
            end
        end
        exp_valor = m_val[3] * 512 + m_val[2] * 64 + m_val[1] * 8 + m_val[0];
        chk("model_valor",      int'(bus_if.valor),      exp_valor);
        chk("model_valido",     int'(bus_if.valido),     int'(m_valido));
        chk("model_erro",       int'(bus_if.erro),       int'(m_erro));
        chk("model_atualizado", int'(bus_if.atualizado), int'(m_atual));
        if (bus_if.atualizado) pulses++;
    endtask

    task automatic step(input logic [0:6] seg, input logic [3:0] an);
        @(negedge clk);
        check_outputs();
        bus_if.segmentos = seg;
        bus_if.anodos    = an;
        model_sample(seg, an);
    endtask

    task automatic hold(input logic [0:6] seg, input logic [3:0] an, input int n);
        repeat (n) step(seg, an);
    endtask

    // Inputs keep their current value through reset; release counts as a sample
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_valor",      int'(bus_if.valor),      0);
        chk("reset_valido",     int'(bus_if.valido),     0);
        chk("reset_erro",       int'(bus_if.erro),       0);
        chk("reset_atualizado", int'(bus_if.atualizado), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        model_sample(bus_if.segmentos, bus_if.anodos);
        pulses = 0;
    endtask

    initial begin
        pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010; pat[3] = 7'b0000110;
        pat[4] = 7'b1001100; pat[5] = 7'b0100100; pat[6] = 7'b0100000; pat[7] = 7'b0001111;

        tbl[0]  = '{4'b1110, 7'b0010010,  4, 1, 12'h002, 4'b0001, 4'b0000};
        tbl[1]  = '{4'b1011, 7'b1111111,  4, 1, 12'h000, 4'b0000, 4'b0100};
        tbl[2]  = '{4'b1101, 7'b0000001,  4, 1, 12'h000, 4'b0010, 4'b0000};
        tbl[3]  = '{4'b0111, 7'b0001111,  6, 1, 12'hE00, 4'b1000, 4'b0000};
        tbl[4]  = '{4'b1110, 7'b1001100,  3, 0, 12'h000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1100, 7'b0000001, 20, 0, 12'h000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1111, 7'b0000001, 20, 0, 12'h000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1011, 7'b0100000, 10, 1, 12'h180, 4'b0100, 4'b0000};
        tbl[8]  = '{4'b1101, 7'b0000110,  4, 1, 12'h018, 4'b0010, 4'b0000};
        tbl[9]  = '{4'b1110, 7'b0100100,  4, 1, 12'h005, 4'b0001, 4'b0000};
        tbl[10] = '{4'b0111, 7'b1001111,  5, 1, 12'h200, 4'b1000, 4'b0000};
        tbl[11] = '{4'b1101, 7'b0100101,  4, 1, 12'h000, 4'b0000, 4'b0010};
        tbl[12] = '{4'b0000, 7'b0000001,  8, 0, 12'h000, 4'b0000, 4'b0000};

        bus_if.segmentos = idle_seg;
        bus_if.anodos    = idle_an;
        model_clear();

        for (int i = 0; i < 13; i++) begin
            bus_if.segmentos = idle_seg;
            bus_if.anodos    = idle_an;
            do_reset();
            hold(tbl[i].seg, tbl[i].an, tbl[i].hold);
            hold(idle_seg, idle_an, 3);
            chk($sformatf("tbl%0d_pulses", i), pulses, tbl[i].exp_pulses);
            chk($sformatf("tbl%0d_valor", i),  int'(bus_if.valor),  int'(tbl[i].exp_valor));
            chk($sformatf("tbl%0d_valido", i), int'(bus_if.valido), int'(tbl[i].exp_valido));
            chk($sformatf("tbl%0d_erro", i),   int'(bus_if.erro),   int'(tbl[i].exp_erro));
        end

        // Pattern change mid-count restarts the count
        do_reset();
        hold(pat[4], 4'b1101, 3);
        hold(pat[7], 4'b1101, 4);
        hold(idle_seg, idle_an, 3);
        chk("restart_pulses", pulses, 1);
        chk("restart_digit1", int'(bus_if.valor[5:3]), 7);

        // Illegal capture keeps the earlier legal value
        do_reset();
        hold(pat[6], 4'b1011, 4);
        hold(idle_seg, idle_an, 2);
        hold(7'b1111111, 4'b1011, 4);
        hold(idle_seg, idle_an, 3);
        chk("illegal_keep_valor", int'(bus_if.valor[8:6]), 6);
        chk("illegal_erro2",      int'(bus_if.erro[2]),    1);
        chk("illegal_valido2",    int'(bus_if.valido[2]),  0);

        // Reset mid-count: three post-reset samples must not capture
        do_reset();
        hold(pat[5], 4'b1110, 2);
        do_reset();
        hold(pat[5], 4'b1110, 2);
        hold(idle_seg, idle_an, 3);
        chk("rstmid_no_capture", pulses, 0);
        do_reset();
        hold(pat[5], 4'b1110, 2);
        do_reset();
        hold(pat[5], 4'b1110, 3);
        hold(idle_seg, idle_an, 3);
        chk("rstmid_4th_capture", pulses, 1);
        chk("rstmid_digit0", int'(bus_if.valor[2:0]), 5);

        // Multiplexed scan of all four digits, two rounds
        do_reset();
        repeat (2) begin
            hold(pat[3], 4'b1110, 8);
            hold(pat[1], 4'b1101, 8);
            hold(pat[6], 4'b1011, 8);
            hold(pat[0], 4'b0111, 8);
        end
        hold(idle_seg, idle_an, 3);
        chk("scan_valor",  int'(bus_if.valor),  int'(12'b000_110_001_011));
        chk("scan_valido", int'(bus_if.valido), 15);
        chk("scan_pulses", pulses, 8);

        // Random dwell sequences checked cycle by cycle against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            logic [3:0] an;
            logic [0:6] seg;
            int n;
            if ($urandom_range(0, 9) < 8) begin
                an = 4'b1111;
                an[$urandom_range(0, 3)] = 1'b0;
            end else begin
                an = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) < 7) seg = pat[$urandom_range(0, 7)];
            else seg = 7'($urandom_range(0, 127));
            n = $urandom_range(1, 7);
            if (k == 150) do_reset();
            hold(seg, an, n);
        end
        hold(idle_seg, idle_an, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a capture (legal range 2..255).
REQ-002 SHALL have port clock  input  1  single clock, all state updated on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port segmentos  input  [0:6]  active-low segment lines, bit 0 = segment a through bit 6 = segment g.
REQ-005 SHALL have port anodos  input  4  active-low digit enables of a multiplexed display, digit i selected when only bit i is 0.
REQ-006 SHALL have port valor  output  12  captured digit values, digit i in bits [3i+2:3i].
REQ-007 SHALL have port valido  output  4  bit i set once digit i holds a legal captured value.
REQ-008 SHALL have port erro  output  4  bit i set when the last capture of digit i was an illegal pattern.
REQ-009 SHALL have port atualizado  output  1  one-cycle pulse on every capture, legal or illegal.

Function
REQ-010 SHALL register segmentos and anodos once at input before any comparison; all latencies below count from this register.
REQ-011 SHALL map legal patterns (a..g) to values: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7; any other pattern is illegal.
REQ-012 SHALL implement states OCIOSO, CONTANDO, CAPTURADO.
REQ-013 OCIOSO: SHALL move to CONTANDO with counter = 1 when registered anodos has exactly one zero bit; otherwise stay.
REQ-014 CONTANDO: SHALL increment the counter while segmentos and anodos equal the previous sample; SHALL restart at counter = 1 on any change when anodos is still one-hot; SHALL return to OCIOSO when anodos is not one-hot.
REQ-015 SHALL capture when the counter reaches STABLE_CYCLES, then move to CAPTURADO; valor/valido/erro/atualizado SHALL update on the same edge as the transition.
REQ-016 Legal capture for digit i: SHALL write value to valor[3i+2:3i], set valido[i], clear erro[i].
REQ-017 Illegal capture for digit i: SHALL set erro[i], clear valido[i], leave valor[3i+2:3i] unchanged.
REQ-018 CAPTURADO: SHALL hold without re-capturing while the sample is unchanged; on any change SHALL behave as in REQ-014 (restart or return to OCIOSO).
REQ-019 Counter SHALL saturate at STABLE_CYCLES and never wrap.
REQ-020 Anodos all-ones or with two or more zeros SHALL never cause a capture.
REQ-021 Digits not captured SHALL retain their last valor/valido/erro indefinitely.

Reset
REQ-022 On reset_n low, SHALL immediately force state OCIOSO, counter 0, input registers to all-ones, valor 0, valido 0, erro 0, atualizado 0.
REQ-023 Reset asserted mid-count SHALL discard the partial count; no capture after release until STABLE_CYCLES fresh stable samples.

Structure
REQ-024 Shared package SHALL hold the eight segment pattern constants, the state enumeration and the digit count (4).
REQ-025 SHALL instantiate one combinational sub-module seg_para_valor (pattern in; 3-bit value and legal flag out).

Verification
REQ-026 anodos=1110, segmentos=0010010 held 4 cycles -> atualizado pulses once, valor[2:0]=2, valido=0001, erro=0000.
REQ-027 anodos=1011, segmentos=1111111 held 4 cycles -> erro[2]=1, valido[2]=0, valor[8:6] unchanged.
REQ-028 anodos=1101, pattern 4 held 3 cycles then pattern 7 held 4 cycles -> single capture, valor[5:3]=7.
REQ-029 anodos=1100 or 1111 with pattern 0 held 20 cycles -> no atualizado, outputs unchanged.
REQ-030 Pattern 5 on digit 0 held 2 cycles, reset_n pulsed low, then held 3 cycles -> no capture; capture only on 4th post-reset stable cycle.
REQ-031 Scan 1110/1101/1011/0111 with 3,1,6,0, 8 cycles each, looping -> valor=000_110_001_011, valido=1111, one pulse per digit dwell.
